fifo_pack_flush: RTL and testbench

//  Parametrised packing FIFO. Accepts LANE_W-bit writes, packs LANES of them into one row
//  (lane 0 = LSBs) and stores up to DEPTH rows. Rows are read out whole.

---
 rtl/fifo_pack_flush.sv | 101 ++++++++++
 tb/tb_fifo_pack_flush.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_pack_flush.sv
// fifo_pack_flush: packs LANE_W-bit beats into LANES-wide rows held DEPTH deep,
// with an edge-triggered flush that pads the partial row and then drains.
module fifo_pack_flush #(
    parameter int LANE_W = 4,
    parameter int LANES = 8,
    parameter int DEPTH = 4,
    parameter logic [LANE_W-1:0] PAD_VAL = 'hC
) (
    input  logic clk,
    input  logic reset,
    input  logic wr_valid_i,
    input  logic [LANE_W-1:0] wr_data_i,
    output logic wr_ready_o,
    input  logic rd_valid_i,
    output logic rd_avail_o,
    output logic [LANES*LANE_W-1:0] rd_data_o,
    output logic [$clog2(LANES+1)-1:0] rd_lanes_o,
    output logic rd_last_o,
    input  logic flush_i,
    output logic flush_busy_o,
    output logic flush_done_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic empty_o,
    output logic full_o
);
    localparam int LPW = $clog2(LANES);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int NW = $clog2(LANES + 1);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int RW = LANES * LANE_W;

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t state, state_nx;
    logic [LPW-1:0] lane_ptr;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic flush_q;
    logic [RW-1:0] asm_q, row_w, row_c;
    logic [RW-1:0] mem_data [DEPTH];
    logic [NW-1:0] mem_lanes [DEPTH];
    logic [DEPTH-1:0] mem_last;
    logic wr_fire, pop, flush_acc, commit;
    logic [NW-1:0] n;

    assign count_o = CW'(wr_ptr - rd_ptr);
    assign full_o = count_o == CW'(DEPTH);
    assign rd_avail_o = count_o != '0;
    assign empty_o = ~rd_avail_o & (lane_ptr == '0);
    assign flush_busy_o = state == DRAIN;
    assign flush_done_o = flush_busy_o & ~rd_avail_o;
    assign wr_ready_o = ~full_o & ~flush_busy_o;
    assign wr_fire = wr_valid_i & wr_ready_o;
    assign pop = rd_valid_i & rd_avail_o;
    assign flush_acc = flush_i & ~flush_q & ~flush_busy_o;
    // n counts beats in the row including one accepted this cycle
    assign n = NW'(lane_ptr) + NW'(wr_fire);
    assign commit = (wr_fire & (lane_ptr == LPW'(LANES - 1))) | (flush_acc & (n != '0));
    assign rd_data_o = mem_data[rd_ptr[AW-1:0]];
    assign rd_lanes_o = mem_lanes[rd_ptr[AW-1:0]];
    assign rd_last_o = mem_last[rd_ptr[AW-1:0]];

    always_comb begin
        row_w = asm_q;
        row_c = asm_q;
        for (int i = 0; i < LANES; i++) begin
            row_w[i*LANE_W +: LANE_W] = (wr_fire && LPW'(i) == lane_ptr) ? wr_data_i : asm_q[i*LANE_W +: LANE_W];
            row_c[i*LANE_W +: LANE_W] = (flush_acc && NW'(i) >= n) ? PAD_VAL : row_w[i*LANE_W +: LANE_W];
        end
    end

    always_comb begin
        state_nx = state;
        state_nx = (state == IDLE) ? (flush_acc ? DRAIN : IDLE) : (rd_avail_o ? DRAIN : IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            lane_ptr <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            flush_q <= 1'b0;
        end else begin
            state <= state_nx;
            lane_ptr <= commit ? '0 : lane_ptr + LPW'(wr_fire);
            wr_ptr <= wr_ptr + PW'(commit);
            rd_ptr <= rd_ptr + PW'(pop);
            flush_q <= flush_i;
        end
    end

    always_ff @(posedge clk) begin
        asm_q <= row_w;
        if (commit) begin
            mem_data[wr_ptr[AW-1:0]] <= row_c;
            mem_lanes[wr_ptr[AW-1:0]] <= n;
            mem_last[wr_ptr[AW-1:0]] <= flush_acc;
        end
    end
endmodule

// File: tb/tb_fifo_pack_flush.sv
// tb_fifo_pack_flush: directed vector table plus hand sequences for fifo_pack_flush.
module tb_fifo_pack_flush;
    typedef struct {
        logic rst, wv;
        logic [3:0] wd;
        logic rv, fl;
        logic rdy, av;
        logic [31:0] data;
        logic [3:0] lanes;
        logic last, busy, done;
        logic [2:0] cnt;
        logic empty, full;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic wr_valid_i = 1'b0;
    logic [3:0] wr_data_i = '0;
    logic wr_ready_o;
    logic rd_valid_i = 1'b0;
    logic rd_avail_o;
    logic [31:0] rd_data_o;
    logic [3:0] rd_lanes_o;
    logic rd_last_o;
    logic flush_i = 1'b0;
    logic flush_busy_o;
    logic flush_done_o;
    logic [2:0] count_o;
    logic empty_o;
    logic full_o;
    int tests = 0;
    int fails = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    fifo_pack_flush dut (
        .clk(clk),
        .reset(reset),
        .wr_valid_i(wr_valid_i),
        .wr_data_i(wr_data_i),
        .wr_ready_o(wr_ready_o),
        .rd_valid_i(rd_valid_i),
        .rd_avail_o(rd_avail_o),
        .rd_data_o(rd_data_o),
        .rd_lanes_o(rd_lanes_o),
        .rd_last_o(rd_last_o),
        .flush_i(flush_i),
        .flush_busy_o(flush_busy_o),
        .flush_done_o(flush_done_o),
        .count_o(count_o),
        .empty_o(empty_o),
        .full_o(full_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic wv, input logic [3:0] wd, input logic rv, input logic fl);
        reset = r;
        wr_valid_i = wv;
        wr_data_i = wd;
        rd_valid_i = rv;
        flush_i = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic rst, input logic wv, input logic [3:0] wd, input logic rv, input logic fl,
                       input logic rdy, input logic av, input logic [31:0] data, input logic [3:0] lanes,
                       input logic last, input logic busy, input logic done, input logic [2:0] cnt,
                       input logic empty, input logic full);
        tbl.push_back('{rst, wv, wd, rv, fl, rdy, av, data, lanes, last, busy, done, cnt, empty, full});
    endtask

    initial begin
        // reset
        add(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        // full row 1..8, then pop
        for (int i = 1; i < 8; i++) add(0, 1, 4'(i), 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 4'h8, 0, 0, 1, 1, 32'h87654321, 8, 0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        // partial row A,B,C flushed with padding
        add(0, 1, 4'hA, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 4'hB, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 4'hC, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 1, 32'hCCCCCCBA, 3, 1, 1, 0, 1, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        // flush of empty FIFO with flush_i held
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0);
        for (int i = 0; i < 9; i++) add(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);

        step(1, 0, 0, 0, 0);
        foreach (tbl[k]) begin
            step(tbl[k].rst, tbl[k].wv, tbl[k].wd, tbl[k].rv, tbl[k].fl);
            chk($sformatf("v%0d.wr_ready", k), wr_ready_o, tbl[k].rdy);
            chk($sformatf("v%0d.rd_avail", k), rd_avail_o, tbl[k].av);
            chk($sformatf("v%0d.busy", k), flush_busy_o, tbl[k].busy);
            chk($sformatf("v%0d.done", k), flush_done_o, tbl[k].done);
            chk($sformatf("v%0d.count", k), count_o, tbl[k].cnt);
            chk($sformatf("v%0d.empty", k), empty_o, tbl[k].empty);
            chk($sformatf("v%0d.full", k), full_o, tbl[k].full);
            if (tbl[k].av) begin
                chk($sformatf("v%0d.rd_data", k), rd_data_o, tbl[k].data);
                chk($sformatf("v%0d.rd_lanes", k), rd_lanes_o, tbl[k].lanes);
                chk($sformatf("v%0d.rd_last", k), rd_last_o, tbl[k].last);
            end
        end

        // fill to full, dropped beat, commit with simultaneous pop, pointer wrap
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 32; i++) step(0, 1, 4'(i), 0, 0);
        chk("t3.full", full_o, 1);
        chk("t3.wr_ready_full", wr_ready_o, 0);
        chk("t3.count_full", count_o, 4);
        chk("t3.head0", rd_data_o, 32'h76543210);
        step(0, 1, 4'h5, 0, 0);
        chk("t3.count_drop", count_o, 4);
        step(0, 0, 0, 1, 0);
        chk("t3.count_pop", count_o, 3);
        chk("t3.head1", rd_data_o, 32'hFEDCBA98);
        chk("t3.wr_ready_pop", wr_ready_o, 1);
        for (int i = 1; i < 8; i++) step(0, 1, 4'(i), 0, 0);
        chk("t3.count_partial", count_o, 3);
        step(0, 1, 4'h8, 1, 0);
        chk("t3.count_commit_pop", count_o, 3);
        chk("t3.head2", rd_data_o, 32'h76543210);
        for (int i = 9; i < 17; i++) step(0, 1, 4'(i), 0, 0);
        chk("t3.count_refill", count_o, 4);
        chk("t3.full_refill", full_o, 1);
        step(0, 0, 0, 1, 0);
        chk("t3.head3", rd_data_o, 32'hFEDCBA98);
        step(0, 0, 0, 1, 0);
        chk("t3.head4", rd_data_o, 32'h87654321);
        step(0, 0, 0, 1, 0);
        chk("t3.head5", rd_data_o, 32'h0FEDCBA9);
        chk("t3.head5_lanes", rd_lanes_o, 8);
        chk("t3.head5_last", rd_last_o, 0);
        step(0, 0, 0, 1, 0);
        chk("t3.empty_end", empty_o, 1);
        chk("t3.avail_end", rd_avail_o, 0);

        // 8th beat lands in the flush-edge cycle
        step(1, 0, 0, 0, 0);
        for (int i = 1; i < 8; i++) step(0, 1, 4'(i), 0, 0);
        step(0, 1, 4'h8, 0, 1);
        chk("t5.data", rd_data_o, 32'h87654321);
        chk("t5.lanes", rd_lanes_o, 8);
        chk("t5.last", rd_last_o, 1);
        chk("t5.count", count_o, 1);
        chk("t5.busy", flush_busy_o, 1);
        chk("t5.wr_ready", wr_ready_o, 0);
        step(0, 0, 0, 1, 0);
        chk("t5.done", flush_done_o, 1);
        step(0, 0, 0, 0, 0);
        chk("t5.busy_end", flush_busy_o, 0);
        chk("t5.done_end", flush_done_o, 0);
        chk("t5.empty_end", empty_o, 1);

        // reset while draining two rows
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) step(0, 1, 4'(i), 0, 0);
        chk("t6.count", count_o, 2);
        step(0, 0, 0, 0, 1);
        chk("t6.busy", flush_busy_o, 1);
        chk("t6.count_flush", count_o, 2);
        chk("t6.done_early", flush_done_o, 0);
        step(0, 0, 0, 0, 0);
        chk("t6.busy_hold", flush_busy_o, 1);
        step(1, 0, 0, 0, 0);
        chk("t6.count_rst", count_o, 0);
        chk("t6.busy_rst", flush_busy_o, 0);
        chk("t6.done_rst", flush_done_o, 0);
        chk("t6.wr_ready_rst", wr_ready_o, 1);
        chk("t6.empty_rst", empty_o, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0);
            chk($sformatf("t6.no_done%0d", i), flush_done_o, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
